// File: rtl/mvu_pkg.sv
// mvu_pkg: shared constants and arithmetic helpers for the MVU compute core.
//   PIPE_LATENCY  : number of enabled edges from accepting a beat to its result.
//   prod_width    : exact width of one signed weight x (signed or zero-extended) activation product.
//   sext_to_accu  : reinterpret a wide signed value as the content of an accu_w-bit register.
package mvu_pkg;

    localparam int PIPE_LATENCY = 3;

    // One extra bit so an unsigned activation can be zero-extended into a signed operand.
    function automatic int prod_width(input int weight_width, input int activation_width);
        return weight_width + activation_width + 1;
    endfunction

    // Keeps the low accu_w bits and sign-extends them back to 64 bits, i.e. the value an
    // accu_w-bit two's complement accumulator actually holds after wrapping.
    function automatic logic signed [63:0] sext_to_accu(input logic signed [63:0] v, input int accu_w);
        return (v <<< (64 - accu_w)) >>> (64 - accu_w);
    endfunction

endpackage

// File: rtl/mvu_dot_lane.sv
// mvu_dot_lane: one PE lane of the MVU core.
//   Stage S2: SIMD exact multipliers plus an exact adder tree, registered after
//             sign-extension/truncation to ACCU_WIDTH; forced to 0 on bubble beats.
//   Stage S3: wrapping accumulator, restarted from 0 when i_restart is set.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   i_en          stage enable, every register holds when low
//   i_zero        S1 bubble flag, the S2 sum becomes 0 regardless of i_a/i_w
//   i_restart     S3 restart flag, accumulation starts from 0 this edge
//   i_a           S1 activations, element s at s*ACTIVATION_WIDTH
//   i_w           S1 weights for this lane, element s at s*WEIGHT_WIDTH
//   o_acc         accumulator value
// Optional: MVU_LANE_CORE_CHECK_EN enables a simulation warning on signed accumulator overflow.
module mvu_dot_lane
    import mvu_pkg::*;
#(
    parameter int SIMD               = 8,
    parameter int ACTIVATION_WIDTH   = 4,
    parameter int WEIGHT_WIDTH       = 4,
    parameter int ACCU_WIDTH         = 16,
    parameter bit SIGNED_ACTIVATIONS = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_en,
    input  logic                             i_zero,
    input  logic                             i_restart,
    input  logic [SIMD*ACTIVATION_WIDTH-1:0] i_a,
    input  logic [SIMD*WEIGHT_WIDTH-1:0]     i_w,
    output logic [ACCU_WIDTH-1:0]            o_acc
);

    localparam int PW = prod_width(WEIGHT_WIDTH, ACTIVATION_WIDTH);
    localparam int DW = PW + $clog2(SIMD);

    logic signed [PW-1:0]         w_prod [SIMD];
    logic signed [DW-1:0]         w_dot;
    logic        [ACCU_WIDTH-1:0] r_sum;
    logic        [ACCU_WIDTH-1:0] r_acc;

    for (genvar s = 0; s < SIMD; s++) begin : g_mul
        logic signed [WEIGHT_WIDTH-1:0] w_wt;
        logic signed [ACTIVATION_WIDTH:0] w_act;
        assign w_wt  = i_w[s*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        // The top bit either replicates the sign or is a zero pad, so the multiply is always signed.
        assign w_act = SIGNED_ACTIVATIONS
                     ? {i_a[s*ACTIVATION_WIDTH + ACTIVATION_WIDTH - 1], i_a[s*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]}
                     : {1'b0, i_a[s*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]};
        assign w_prod[s] = PW'(w_wt) * PW'(w_act);
    end

    always_comb begin
        w_dot = '0;
        for (int s = 0; s < SIMD; s++) begin
            w_dot = w_dot + DW'(w_prod[s]);
        end
    end

    // The bubble mux sits in front of the register so undefined bubble data never reaches r_acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
            r_acc <= '0;
        end else if (i_en) begin
            r_sum <= i_zero ? '0 : ACCU_WIDTH'(w_dot);
            r_acc <= (i_restart ? '0 : r_acc) + r_sum;
        end
    end

    assign o_acc = r_acc;

`ifdef MVU_LANE_CORE_CHECK_EN
    logic signed [63:0] w_exactNext;
    assign w_exactNext = 64'($signed(i_restart ? '0 : r_acc)) + 64'($signed(r_sum));

    always @(posedge clk) begin
        if (!rst && i_en && (sext_to_accu(w_exactNext, ACCU_WIDTH) != w_exactNext)) begin
            $warning("mvu_dot_lane: signed accumulator overflow");
        end
    end
`endif

endmodule

// File: rtl/mvu_lane_core.sv
// mvu_lane_core: compute core of the matrix-vector unit.
//   Three-stage pipeline advancing only on enabled edges:
//     S1 registers activations, weights, last&!zero and zero (shared by all lanes);
//     S2 forms each lane's SIMD-wide dot product (inside mvu_dot_lane);
//     S3 accumulates per lane and raises vld for a beat that closed a vector.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   en         global enable, all registers hold when low
//   last       beat closes a dot-product vector (ignored on bubbles)
//   zero       bubble beat, contributes nothing
//   w          PE*SIMD weights, element [pe][s] at (pe*SIMD+s)*WEIGHT_WIDTH
//   a          SIMD activations, element [s] at s*ACTIVATION_WIDTH
//   vld        p holds a completed result
//   p          PE results, lane pe at pe*ACCU_WIDTH
// Optional: MVU_LANE_CORE_CHECK_EN enables simulation-only parameter, X and overflow checks.
module mvu_lane_core
    import mvu_pkg::*;
#(
    parameter int PE                 = 4,
    parameter int SIMD               = 8,
    parameter int ACTIVATION_WIDTH   = 4,
    parameter int WEIGHT_WIDTH       = 4,
    parameter int ACCU_WIDTH         = 16,
    parameter bit SIGNED_ACTIVATIONS = 1'b0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                last,
    input  logic                                zero,
    input  logic [PE*SIMD*WEIGHT_WIDTH-1:0]     w,
    input  logic [SIMD*ACTIVATION_WIDTH-1:0]    a,
    output logic                                vld,
    output logic [PE*ACCU_WIDTH-1:0]            p
);

    logic [SIMD*ACTIVATION_WIDTH-1:0] r_a;
    logic [PE*SIMD*WEIGHT_WIDTH-1:0]  r_w;
    logic                             r_last1;
    logic                             r_zero1;
    logic                             r_last2;
    logic                             r_restart;
    logic                             r_vld;

    // Data registers are cleared on reset too, so a cleared zero flag still yields a zero sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_w     <= '0;
            r_last1 <= 1'b0;
            r_zero1 <= 1'b0;
        end else if (en) begin
            r_a     <= a;
            r_w     <= w;
            r_last1 <= last & ~zero;
            r_zero1 <= zero;
        end
    end

    // restart starts high so the first vector after reset begins from 0 without a clear cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last2   <= 1'b0;
            r_restart <= 1'b1;
            r_vld     <= 1'b0;
        end else if (en) begin
            r_last2   <= r_last1;
            r_restart <= r_last2;
            r_vld     <= r_last2;
        end
    end

    for (genvar pe = 0; pe < PE; pe++) begin : g_lane
        mvu_dot_lane #(
            .SIMD               (SIMD),
            .ACTIVATION_WIDTH   (ACTIVATION_WIDTH),
            .WEIGHT_WIDTH       (WEIGHT_WIDTH),
            .ACCU_WIDTH         (ACCU_WIDTH),
            .SIGNED_ACTIVATIONS (SIGNED_ACTIVATIONS)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_en      (en),
            .i_zero    (r_zero1),
            .i_restart (r_restart),
            .i_a       (r_a),
            .i_w       (r_w[pe*SIMD*WEIGHT_WIDTH +: SIMD*WEIGHT_WIDTH]),
            .o_acc     (p[pe*ACCU_WIDTH +: ACCU_WIDTH])
        );
    end

    assign vld = r_vld;

`ifdef MVU_LANE_CORE_CHECK_EN
    if (ACTIVATION_WIDTH < 1 || ACTIVATION_WIDTH > 9) begin : g_badActWidth
        $error("mvu_lane_core: ACTIVATION_WIDTH must be 1..9");
    end
    if (ACTIVATION_WIDTH == 9 && !SIGNED_ACTIVATIONS) begin : g_badActSign
        $error("mvu_lane_core: ACTIVATION_WIDTH=9 requires SIGNED_ACTIVATIONS=1");
    end
    if (WEIGHT_WIDTH < 1 || WEIGHT_WIDTH > 8) begin : g_badWeightWidth
        $error("mvu_lane_core: WEIGHT_WIDTH must be 1..8");
    end
    if (ACCU_WIDTH < 1 || ACCU_WIDTH > 63 || PE < 1 || SIMD < 1) begin : g_badShape
        $error("mvu_lane_core: PE, SIMD and ACCU_WIDTH out of range");
    end

    always @(posedge clk) begin
        if (!rst && $isunknown({en, last, zero})) begin
            $error("mvu_lane_core: X on en/last/zero");
        end
    end
`endif

endmodule

// File: tb/tb_mvu_lane_core.sv
// tb_mvu_lane_core: self-checking bench for mvu_lane_core.
//   Main DUT: PE=2, SIMD=2, unsigned 4b activations, 4b weights, 16b accumulators.
//   Aux DUTs share the stimulus: one with signed activations, one with 8b accumulators.
//   Expected main-DUT results go into a scoreboard queue when the closing beat is driven
//   and are popped by a monitor whenever vld is seen after an enabled edge.
module tb_mvu_lane_core;

    typedef struct {
        logic [15:0] p0;
        logic [15:0] p1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        last;
    logic        zero;
    logic [15:0] w;
    logic [7:0]  a;
    logic        vldM, vldS, vldW;
    logic [31:0] pM, pS;
    logic [15:0] pW;

    exp_t sbQ[$];
    exp_t monExp;
    int   errors = 0;
    int   checks = 0;
    bit   sawEnEdge = 1'b0;

    mvu_lane_core #(.PE(2), .SIMD(2), .ACTIVATION_WIDTH(4), .WEIGHT_WIDTH(4),
                    .ACCU_WIDTH(16), .SIGNED_ACTIVATIONS(1'b0)) u_dutMain (
        .clk(clk), .rst(rst), .en(en), .last(last), .zero(zero),
        .w(w), .a(a), .vld(vldM), .p(pM));

    mvu_lane_core #(.PE(2), .SIMD(2), .ACTIVATION_WIDTH(4), .WEIGHT_WIDTH(4),
                    .ACCU_WIDTH(16), .SIGNED_ACTIVATIONS(1'b1)) u_dutSigned (
        .clk(clk), .rst(rst), .en(en), .last(last), .zero(zero),
        .w(w), .a(a), .vld(vldS), .p(pS));

    mvu_lane_core #(.PE(2), .SIMD(2), .ACTIVATION_WIDTH(4), .WEIGHT_WIDTH(4),
                    .ACCU_WIDTH(8), .SIGNED_ACTIVATIONS(1'b0)) u_dutWrap (
        .clk(clk), .rst(rst), .en(en), .last(last), .zero(zero),
        .w(w), .a(a), .vld(vldW), .p(pW));

    always #5 clk = ~clk;

    // Bench model of one lane: 4b raw codes interpreted as the DUT should.
    function automatic int actVal(input int raw, input bit sgn);
        logic [3:0] r;
        r = 4'(raw);
        return sgn ? int'($signed(r)) : int'(r);
    endfunction

    function automatic int wVal(input int raw);
        logic [3:0] r;
        r = 4'(raw);
        return int'($signed(r));
    endfunction

    function automatic int lane(input int a0, input int a1, input int w0, input int w1, input bit sgn);
        return actVal(a0, sgn) * wVal(w0) + actVal(a1, sgn) * wVal(w1);
    endfunction

    function automatic exp_t mkExp(input int v0, input int v1);
        exp_t e;
        e.p0 = 16'(v0);
        e.p1 = 16'(v1);
        return e;
    endfunction

    // Records whether the most recent edge actually advanced the pipeline.
    always @(posedge clk) sawEnEdge = en && !rst;

    // Scoreboard monitor: every fresh vld must match the oldest expected result.
    always @(negedge clk) begin
        if (sawEnEdge && vldM === 1'b1) begin
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard_extra: vld with p=%h, required no result pending", pM);
            end else begin
                monExp = sbQ.pop_front();
                if (pM !== {monExp.p1, monExp.p0}) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_p: got %h, required %h", pM, {monExp.p1, monExp.p0});
                end
            end
        end
    end

    // Drives one beat at a negedge and returns at the following negedge.
    task automatic driveBeat(input int a0, input int a1, input int w00, input int w01,
                             input int w10, input int w11, input logic lst, input logic zr);
        a    = {4'(a1), 4'(a0)};
        w    = {4'(w11), 4'(w10), 4'(w01), 4'(w00)};
        last = lst;
        zero = zr;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bubble beats carry undefined data and a random last flag, both of which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            a    = 'x;
            w    = 'x;
            last = 1'($urandom_range(0, 1));
            zero = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b0;
        idle(2);
        checks++;
        if (vldM !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_vld: got %b, required 0", vldM);
        end
        checks++;
        if (pM !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_p: got %h, required 0", pM);
        end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_single_beat;
        sbQ.push_back(mkExp(lane(3, 5, 1, 2, 0), lane(3, 5, -1, 3, 0)));
        driveBeat(3, 5, 1, 2, -1, 3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (vldM !== (i == 2)) begin
                errors++;
                $display("[TB] FAIL single_latency[%0d]: vld=%b, required %b", i, vldM, (i == 2));
            end
            idle(1);
        end
    endtask

    task automatic test_bubbles;
        int vldCount;
        vldCount = 0;
        driveBeat(1, 1, 1, 1, 0, -1, 1'b0, 1'b0);
        idle(2);
        driveBeat(1, 1, 1, 1, 0, -1, 1'b0, 1'b0);
        driveBeat(1, 1, 1, 1, 0, -1, 1'b1, 1'b1);
        sbQ.push_back(mkExp(3 * lane(1, 1, 1, 1, 0), 3 * lane(1, 1, 0, -1, 0)));
        driveBeat(1, 1, 1, 1, 0, -1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (vldM === 1'b1) vldCount++;
        end
        checks++;
        if (vldCount != 1) begin
            errors++;
            $display("[TB] FAIL bubbles_vld_count: got %0d, required 1", vldCount);
        end
    endtask

    task automatic test_stall;
        exp_t e;
        e = mkExp(lane(2, 3, -2, 1, 0), lane(2, 3, 7, 7, 0));
        sbQ.push_back(e);
        driveBeat(2, 3, -2, 1, 7, 7, 1'b1, 1'b0);
        idle(1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            checks++;
            if (vldM !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_s2_vld[%0d]: got %b, required 0", i, vldM);
            end
        end
        en = 1'b1;
        idle(1);
        checks++;
        if (vldM !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_third_edge_vld: got %b, required 1", vldM);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            checks++;
            if ({vldM, pM} !== {1'b1, e.p1, e.p0}) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: got vld=%b p=%h, required vld=1 p=%h",
                         i, vldM, pM, {e.p1, e.p0});
            end
        end
        en = 1'b1;
        idle(1);
        checks++;
        if (vldM !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_vld_drop: got %b, required 0", vldM);
        end
    endtask

    task automatic test_extremes;
        logic [31:0] sExpA, sExpB;
        logic [15:0] wExp;
        sExpA = {16'(lane(15, 15, 7, 7, 1)), 16'(lane(15, 15, -8, -8, 1))};
        sExpB = {16'(lane(8, 8, 7, 7, 1)), 16'(lane(8, 8, -8, -8, 1))};
        wExp  = {8'(lane(15, 15, 1, 0, 0) + lane(6, 1, 0, 0, 0)),
                 8'(lane(15, 15, 7, 7, 0) + lane(6, 1, 7, 4, 0))};
        sbQ.push_back(mkExp(lane(15, 15, -8, -8, 0), lane(15, 15, 7, 7, 0)));
        driveBeat(15, 15, -8, -8, 7, 7, 1'b1, 1'b0);
        sbQ.push_back(mkExp(lane(8, 8, -8, -8, 0), lane(8, 8, 7, 7, 0)));
        driveBeat(8, 8, -8, -8, 7, 7, 1'b1, 1'b0);
        driveBeat(15, 15, 7, 7, 1, 0, 1'b0, 1'b0);
        checks++;
        if ({vldS, pS} !== {1'b1, sExpA}) begin
            errors++;
            $display("[TB] FAIL signed_act_a: got vld=%b p=%h, required vld=1 p=%h", vldS, pS, sExpA);
        end
        sbQ.push_back(mkExp(lane(15, 15, 7, 7, 0) + lane(6, 1, 7, 4, 0),
                            lane(15, 15, 1, 0, 0) + lane(6, 1, 0, 0, 0)));
        driveBeat(6, 1, 7, 4, 0, 0, 1'b1, 1'b0);
        checks++;
        if ({vldS, pS} !== {1'b1, sExpB}) begin
            errors++;
            $display("[TB] FAIL signed_act_b: got vld=%b p=%h, required vld=1 p=%h", vldS, pS, sExpB);
        end
        idle(2);
        checks++;
        if ({vldW, pW} !== {1'b1, wExp}) begin
            errors++;
            $display("[TB] FAIL accu_wrap: got vld=%b p=%h, required vld=1 p=%h", vldW, pW, wExp);
        end
        idle(1);
    endtask

    task automatic test_back_to_back;
        for (int k = 1; k <= 3; k++) begin
            sbQ.push_back(mkExp(lane(1, 0, k, 0, 0), 0));
            driveBeat(1, 0, k, 0, 0, 0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (vldM !== (i < 3)) begin
                errors++;
                $display("[TB] FAIL b2b_vld[%0d]: got %b, required %b", i, vldM, (i < 3));
            end
            idle(1);
        end
    endtask

    task automatic test_reset_mid;
        driveBeat(1, 1, 1, 1, 1, 0, 1'b0, 1'b0);
        driveBeat(1, 1, 1, 1, 1, 0, 1'b0, 1'b0);
        rst = 1'b1;
        driveBeat(1, 1, 1, 1, 1, 0, 1'b1, 1'b0);
        checks++;
        if ({vldM, pM} !== 33'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got vld=%b p=%h, required vld=0 p=0", vldM, pM);
        end
        rst = 1'b0;
        driveBeat(1, 1, 1, 1, 1, 0, 1'b0, 1'b0);
        driveBeat(1, 1, 1, 1, 1, 0, 1'b0, 1'b0);
        sbQ.push_back(mkExp(3 * lane(1, 1, 1, 1, 0), 3 * lane(1, 1, 1, 0, 0)));
        driveBeat(1, 1, 1, 1, 1, 0, 1'b1, 1'b0);
        idle(4);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        last = 1'b0;
        zero = 1'b1;
        a    = '0;
        w    = '0;
        @(negedge clk);
        test_reset();
        test_single_beat();
        test_bubbles();
        test_stall();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d results never produced, required 0", sbQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mvu_lane_core.md
Name: mvu_lane_core

Overview:
- Compute core of the matrix-vector unit (MVU).
- Each enabled cycle it takes one beat: SIMD activations plus PE×SIMD weights. Each of the PE lanes forms a SIMD-wide dot product and accumulates it over beats until a beat flagged `last`.
- It then presents the PE accumulated results with `vld`.
- Sits between the activation replay buffer / weight stream and the output register slice of the AXI MVU wrapper. The wrapper stalls the core through `en`.

Parameters:
- PE, 4: number of output lanes (matrix rows processed in parallel).
- SIMD, 8: activations per beat, i.e. the dot-product width.
- ACTIVATION_WIDTH, 4: activation bit width, 1..9. The value 9 is only legal when SIGNED_ACTIVATIONS=1.
- WEIGHT_WIDTH, 4: weight bit width, 1..8. Weights are always signed two's complement.
- ACCU_WIDTH, 16: accumulator and output width per lane.
- SIGNED_ACTIVATIONS, 0: 1 means activations are signed; 0 means they are zero-extended.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  global clock enable. When 0, every register holds.
- last  in  1  current beat is the final beat of a dot-product vector.
- zero  in  1  current beat is a bubble: contributes 0 and `last` is ignored.
- w  in  PE*SIMD*WEIGHT_WIDTH  weights. Element [pe][s] is at bits (pe*SIMD+s)*WEIGHT_WIDTH.
- a  in  SIMD*ACTIVATION_WIDTH  activations. Element [s] is at bits s*ACTIVATION_WIDTH.
- vld  out  1  p holds a completed result.
- p  out  PE*ACCU_WIDTH  results. Lane pe is at bits pe*ACCU_WIDTH.

Behaviour:
- Pipeline has 3 stages, and every stage advances only on edges where en=1.
  - S1 registers a, w, last&!zero, and zero.
  - S2 registers per-lane sum_s(w[pe][s]*a[s]); the sum is forced to 0 if the zero flag is set.
  - S3 is the accumulator: acc <= (restart ? 0 : acc) + sum. Then restart <= last_S2 and vld <= last_S2.
- Latency: a beat with last=1 and zero=0 accepted at enabled edge k makes vld=1 after enabled edge k+2, i.e. 3 enabled edges.
- p = acc, valid while vld=1. vld and p hold unchanged while en=0.
- vld drops after the next enabled edge unless another last reaches S3; with last every beat, vld stays high continuously.
- The first beat after a result, or after reset, starts from 0; no separate clear cycle is needed.
- zero=1 beats:
  - contribute nothing, do not end the vector, and do not disturb the partial sum;
  - may appear anywhere, including consecutively.
- Arithmetic:
  - Weights are signed.
  - Activations are signed or unsigned according to SIGNED_ACTIVATIONS.
  - Each product is exact at WEIGHT_WIDTH+ACTIVATION_WIDTH+1 bits; the tree sum is exact.
  - Values are sign-extended or truncated to ACCU_WIDTH, and the accumulation wraps modulo 2^ACCU_WIDTH.
- Reset:
  - vld=0, p=0, acc=0, restart=1, and all pipeline last/zero flags cleared;
  - in-flight beats are discarded. Reset mid-vector means the next vector starts clean.
- en=0 while rst=1: reset still takes effect.
- Inputs other than en/rst/last/zero may be X during zero=1 beats; X must not propagate into acc.

Optional Feature:
- Macro MVU_LANE_CORE_CHECK_EN.
- When defined, simulation-only assertions flag:
  - X on en, last, or zero after reset;
  - parameter violations at elaboration (widths out of range, ACTIVATION_WIDTH=9 while unsigned);
  - signed overflow of any lane's accumulator, reported as a warning.
- When undefined, there are no checks. Synthesized logic and cycle behaviour are identical either way.

Decomposition:
- Package mvu_pkg holds:
  - localparam PIPE_LATENCY=3;
  - function prod_width(WEIGHT_WIDTH, ACTIVATION_WIDTH);
  - function sext_to_accu for the extension rules.
- One natural sub-module: mvu_dot_lane (one PE lane: SIMD multipliers, adder tree, accumulator), generated PE times. Shared S1 and control flags stay in the top.

Test Plan:
- PE=2, SIMD=2, unsigned 4b act, 4b weights, en=1, single beat last=1:
  - inputs: a={3,5}, w0={1,2}, w1={-1,3};
  - response: 3 edges later vld=1 for 1 cycle, p0=13, p1=12.
- Same config, SF=3 vector with a={1,1} and w0={1,1} each beat, and zero=1 bubbles between beats → single vld, p0=6; bubbles add 0.
- en=0 for 5 cycles while the result sits in S2 and again while vld=1 → vld rises only after 3 enabled edges; p and vld hold during stalls.
- Extremes, SIMD=2:
  - unsigned: w=-8, a=15 → p=-240;
  - SIGNED_ACTIVATIONS=1: w=-8, a=-8 → p=128;
  - ACCU_WIDTH=8 with sum 256 → p=0 (wrap).
- Back-to-back last=1 every cycle with a={1,0}, w0 values 1,2,3 → vld high 3 consecutive cycles, p0=1,2,3, no carry-over between vectors.
- rst pulse after 2 of 3 beats, then a fresh SF=3 vector of ones → vld=0 during reset, next result p0=6 with no residue.
